// File: rtl/hbm_wt_pkg.sv
// ----------------------------------------------------------------------------
// hbm_wt_pkg
//   Shared definitions for the HBM weight group packer: FSM state encoding
//   and the constant functions that size a group and a block.
// ----------------------------------------------------------------------------
package hbm_wt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WT    = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Blocks per group: one scale beat carries this many scales.
    function automatic int group_blocks(input int axi_dw, input int scale_dw);
        return axi_dw / scale_dw;
    endfunction

    // Output beats needed to carry the weights of one quant block.
    function automatic int beats_per_block(input int t_quant_block, input int wt_dw,
                                           input int axi_dw);
        return (t_quant_block * wt_dw) / axi_dw;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hbm_wt_group_packer_if.sv
// ----------------------------------------------------------------------------
// hbm_wt_group_packer_if
//   Stream bundle of the packer: quant-block input (in_*) and beat output
//   (out_*).
//   slave  : packer side  (consumes blocks, produces beats)
//   master : producer/consumer side (drives blocks, accepts beats)
// ----------------------------------------------------------------------------
interface hbm_wt_group_packer_if #(
    parameter int HBM_AXI_DATA_WIDTH = 256,
    parameter int T_QUANT_BLOCK      = 128,
    parameter int WT_DW              = 4,
    parameter int SCALE_DW           = 16
);
    logic                                in_valid;
    logic                                in_ready;
    logic [T_QUANT_BLOCK*WT_DW-1:0]      in_wt;
    logic [SCALE_DW-1:0]                 in_scale;
    logic                                out_valid;
    logic                                out_ready;
    logic [HBM_AXI_DATA_WIDTH-1:0]       out_data;
    logic                                out_last;

    modport slave (
        input  in_valid, in_wt, in_scale, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_wt, in_scale, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/hbm_scale_collector.sv
// ----------------------------------------------------------------------------
// hbm_scale_collector
//   Accumulates the scales of one group into a full-width scale beat.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : zero every slot (after a scale beat is sent)
//     wr_en      : write wr_scale into slot wr_slot
//     wr_slot    : slot index = position of the block within its group
//     wr_scale   : scale value to store
//     beat       : all slots, slot k at bits [SCALE_DW*k +: SCALE_DW]
// ----------------------------------------------------------------------------
module hbm_scale_collector
    import hbm_wt_pkg::*;
#(
    parameter int SCALE_DW     = 16,
    parameter int GROUP_BLOCKS = 16,
    parameter int SLOT_W       = idx_width(GROUP_BLOCKS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             wr_en,
    input  logic [SLOT_W-1:0]                wr_slot,
    input  logic [SCALE_DW-1:0]              wr_scale,
    output logic [GROUP_BLOCKS*SCALE_DW-1:0] beat
);

    logic [GROUP_BLOCKS-1:0][SCALE_DW-1:0] slots_q;

    // NOTE: this storage is reset even though it is data, because unused slots
    // of a partial group must read back as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q <= '0;
        end else if (clr) begin
            slots_q <= '0;
        end else if (wr_en) begin
            slots_q[wr_slot] <= wr_scale;
        end
    end

    assign beat = slots_q;

endmodule

// File: rtl/hbm_wt_group_packer.sv
// ----------------------------------------------------------------------------
// hbm_wt_group_packer
//   Packs INT4 quant blocks and their FP16 scales into HBM beats. Each row of
//   cfg_blocks blocks is emitted as groups of up to GROUP_BLOCKS blocks: the
//   weight beats of every block in the group (low channels first), then one
//   scale beat holding the group's scales. out_last marks the scale beat that
//   closes a row; done pulses once after the final row.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     start                 : latch cfg_* and begin a job (ignored when busy)
//     cfg_blocks, cfg_rows  : blocks per row, rows per job (both >= 1)
//     bus (slave)           : in_valid/in_ready/in_wt/in_scale block input,
//                             out_valid/out_ready/out_data/out_last beat output
//     busy                  : job in progress
//     done                  : one-cycle pulse at job end
//     stall_cnt             : only with WT_PACK_STALL_CNT_EN defined; cycles
//                             with out_valid && !out_ready, cleared on start,
//                             saturating
// ----------------------------------------------------------------------------
module hbm_wt_group_packer
    import hbm_wt_pkg::*;
#(
    parameter int HBM_AXI_DATA_WIDTH = 256,
    parameter int T_QUANT_BLOCK      = 128,
    parameter int WT_DW              = 4,
    parameter int SCALE_DW           = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [15:0]                cfg_blocks,
    input  logic [15:0]                cfg_rows,
    hbm_wt_group_packer_if.slave       bus,
    output logic                       busy,
    output logic                       done
`ifdef WT_PACK_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);

    localparam int GROUP_BLOCKS    = group_blocks(HBM_AXI_DATA_WIDTH, SCALE_DW);
    localparam int BEATS_PER_BLOCK = beats_per_block(T_QUANT_BLOCK, WT_DW, HBM_AXI_DATA_WIDTH);
    localparam int BEAT_W          = idx_width(BEATS_PER_BLOCK);
    localparam int SLOT_W          = idx_width(GROUP_BLOCKS);
    localparam int GRP_W           = $clog2(GROUP_BLOCKS + 1);

    localparam logic [GRP_W-1:0]  GRP_FULL  = GRP_W'(GROUP_BLOCKS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_BLOCK - 1);

    state_t state_q, state_d;

    logic [15:0]       blocks_q;     // latched cfg_blocks
    logic [15:0]       rows_q;       // latched cfg_rows
    logic [15:0]       row_blk_q;    // blocks accepted in the current row
    logic [15:0]       row_cnt_q;    // current row index
    logic [GRP_W-1:0]  grp_cnt_q;    // blocks accepted in the current group

    logic [BEATS_PER_BLOCK-1:0][HBM_AXI_DATA_WIDTH-1:0] hold_q;
    logic              hold_valid_q;
    logic [BEAT_W-1:0] beat_q;       // next beat of hold_q to send

    logic [HBM_AXI_DATA_WIDTH-1:0] scale_beat;

    logic row_blocks_done, grp_full, last_row;
    logic start_ok, wt_last_fire, hold_fire, scale_fire, accept;
    logic in_ready, out_valid, out_last;
    logic [HBM_AXI_DATA_WIDTH-1:0] out_data;

    // A zero-sized job would wrap the row/block compares, so it never starts.
    assign start_ok        = (state_q == IDLE) && start && (cfg_blocks != 16'd0)
                             && (cfg_rows != 16'd0);
    assign row_blocks_done = (row_blk_q == blocks_q);
    assign grp_full        = (grp_cnt_q == GRP_FULL) || row_blocks_done;
    assign last_row        = (row_cnt_q == rows_q - 16'd1);

    assign hold_fire    = (state_q == WT) && hold_valid_q && bus.out_ready;
    assign wt_last_fire = hold_fire && (beat_q == LAST_BEAT);
    assign scale_fire   = (state_q == SCALE) && bus.out_ready;

    // Refill the holding register in the same cycle its last beat leaves, so
    // consecutive blocks of a group stream without bubbles.
    assign in_ready = (state_q == WT) && !grp_full && (!hold_valid_q || wt_last_fire);
    assign accept   = bus.in_valid && in_ready;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = WT;
            end
            WT: begin
                out_valid = hold_valid_q;
                if (hold_valid_q) out_data = hold_q[beat_q];
                if (wt_last_fire && grp_full) state_d = SCALE;
            end
            SCALE: begin
                out_valid = 1'b1;
                out_data  = scale_beat;
                out_last  = row_blocks_done;
                if (bus.out_ready) begin
                    if (row_blocks_done && last_row) state_d = DONE;
                    else                             state_d = WT;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            blocks_q     <= '0;
            rows_q       <= '0;
            row_blk_q    <= '0;
            row_cnt_q    <= '0;
            grp_cnt_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            beat_q       <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                blocks_q     <= cfg_blocks;
                rows_q       <= cfg_rows;
                row_blk_q    <= '0;
                row_cnt_q    <= '0;
                grp_cnt_q    <= '0;
                hold_valid_q <= 1'b0;
                beat_q       <= '0;
            end else begin
                if (accept) begin
                    hold_q       <= bus.in_wt;
                    hold_valid_q <= 1'b1;
                    beat_q       <= '0;
                    row_blk_q    <= row_blk_q + 16'd1;
                    grp_cnt_q    <= grp_cnt_q + GRP_W'(1);
                end else if (hold_fire) begin
                    if (beat_q == LAST_BEAT) begin
                        hold_valid_q <= 1'b0;
                        beat_q       <= '0;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                if (scale_fire) begin
                    grp_cnt_q <= '0;
                    if (row_blocks_done && !last_row) begin
                        row_cnt_q <= row_cnt_q + 16'd1;
                        row_blk_q <= '0;
                    end
                end
            end
        end
    end

    hbm_scale_collector #(
        .SCALE_DW     (SCALE_DW),
        .GROUP_BLOCKS (GROUP_BLOCKS),
        .SLOT_W       (SLOT_W)
    ) u_scale (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (scale_fire || start_ok),
        .wr_en    (accept),
        .wr_slot  (grp_cnt_q[SLOT_W-1:0]),
        .wr_scale (bus.in_scale),
        .beat     (scale_beat)
    );

`ifdef WT_PACK_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (out_valid && !bus.out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hbm_wt_group_packer.sv
// ----------------------------------------------------------------------------
// tb_hbm_wt_group_packer
//   Self-checking bench for hbm_wt_group_packer. Jobs come from a table of
//   {cfg, stall mode, input gap, expected beat/last counts}; beat contents
//   are compared against a group-packing model. Reset-mid-job and idle
//   behaviour are hand-written sequences. Define WT_PACK_STALL_CNT_EN to also
//   check stall_cnt.
// ----------------------------------------------------------------------------
module tb_hbm_wt_group_packer;

    localparam int DW  = 256;
    localparam int TQ  = 128;
    localparam int WDW = 4;
    localparam int SDW = 16;
    localparam int GB  = DW / SDW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_blocks = '0;
    logic [15:0] cfg_rows = '0;
    logic        busy, done;
`ifdef WT_PACK_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hbm_wt_group_packer_if #(
        .HBM_AXI_DATA_WIDTH (DW), .T_QUANT_BLOCK (TQ), .WT_DW (WDW), .SCALE_DW (SDW)
    ) bus ();

    hbm_wt_group_packer #(
        .HBM_AXI_DATA_WIDTH (DW), .T_QUANT_BLOCK (TQ), .WT_DW (WDW), .SCALE_DW (SDW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_blocks (cfg_blocks),
        .cfg_rows   (cfg_rows),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
`ifdef WT_PACK_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int    blocks;
        int    rows;
        bit    stall;
        int    gap;
        bit    busy_start;
        int    exp_beats;
        int    exp_lasts;
        string name;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus data and model ----------------
    function automatic logic [TQ*WDW-1:0] mk_wt(input int tag);
        logic [TQ*WDW-1:0] r;
        for (int w = 0; w < TQ * WDW / 32; w++)
            r[32*w +: 32] = 32'(tag) * 32'h9E37_79B1 + 32'(w) + 32'h100;
        return r;
    endfunction

    function automatic logic [SDW-1:0] mk_scale(input int tag);
        return 16'(tag * 5 + 3);
    endfunction

    logic [DW-1:0] exp_d[$];
    bit            exp_l[$];

    task automatic build_model(input int blocks, input int rows);
        int tag = 0;
        exp_d.delete();
        exp_l.delete();
        for (int r = 0; r < rows; r++) begin
            for (int b0 = 0; b0 < blocks; b0 += GB) begin
                int n;
                logic [DW-1:0] sb;
                logic [TQ*WDW-1:0] w;
                n = (blocks - b0 < GB) ? blocks - b0 : GB;
                sb = '0;
                for (int k = 0; k < n; k++) begin
                    w = mk_wt(tag);
                    exp_d.push_back(w[DW-1:0]);   exp_l.push_back(1'b0);
                    exp_d.push_back(w[2*DW-1:DW]); exp_l.push_back(1'b0);
                    sb[SDW*k +: SDW] = mk_scale(tag);
                    tag++;
                end
                exp_d.push_back(sb);
                exp_l.push_back(b0 + n == blocks);
            end
        end
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    bit            mon_en = 1'b0;
    int            cyc = 0;
    logic [DW-1:0] got_d[$];
    bit            got_l[$];
    int            got_c[$];
    int            stall_seen, stab_err, done_cnt, done_cyc, last_cyc;
    int            first_in_cyc, accepted, valid_seen;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (bus.in_valid && bus.in_ready) begin
                if (first_in_cyc < 0) first_in_cyc = cyc;
                accepted++;
            end
            if (bus.out_valid) valid_seen++;
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data
                               || bus.out_last !== prev_last))
                stab_err++;
            if (bus.out_valid && bus.out_ready) begin
                got_d.push_back(bus.out_data);
                got_l.push_back(bus.out_last);
                got_c.push_back(cyc);
                if (bus.out_last) last_cyc = cyc;
            end
            if (bus.out_valid && !bus.out_ready) stall_seen++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        got_d.delete(); got_l.delete(); got_c.delete();
        stall_seen = 0; stab_err = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
        first_in_cyc = -1; accepted = 0; valid_seen = 0; prev_stall = 1'b0;
    endtask

    // ---------------- drivers ----------------
    bit ready_rand = 1'b0;
    bit abort = 1'b0;

    always @(posedge clk) begin
        #1;
        bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic pulse_start(input int b, input int r);
        @(posedge clk); #1;
        cfg_blocks = 16'(b);
        cfg_rows   = 16'(r);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic feed(input int n, input int gap);
        int t;
        bit stuck = 1'b0;
        for (int b = 0; b < n && !abort && !stuck; b++) begin
            bus.in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            bus.in_wt    = mk_wt(b);
            bus.in_scale = mk_scale(b);
            bus.in_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!bus.in_ready && !abort && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (bus.in_ready && !abort) begin
                @(posedge clk); #1;
            end else begin
                stuck = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int t;
        build_model(v.blocks, v.rows);
        clear_mon();
        ready_rand = v.stall;
        mon_en = 1'b1;
        pulse_start(v.blocks, v.rows);
        fork
            feed(v.blocks * v.rows, v.gap);
            begin
                t = 0;
                while (done_cnt == 0 && t < 20000) begin
                    @(posedge clk);
                    t++;
                end
            end
            begin
                if (v.busy_start) begin
                    repeat (4) @(posedge clk);
                    #1;
                    cfg_blocks = 16'd1;
                    cfg_rows   = 16'd5;
                    start      = 1'b1;
                    @(posedge clk); #1;
                    start      = 1'b0;
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        mon_en = 1'b0;
        ready_rand = 1'b0;

        check({v.name, "_beats"}, got_d.size(), v.exp_beats);
        check({v.name, "_lasts"}, got_l.sum() with (int'(item)), v.exp_lasts);
        check({v.name, "_accepted"}, accepted, v.blocks * v.rows);
        check({v.name, "_done_cnt"}, done_cnt, 1);
        check({v.name, "_stable"}, stab_err, 0);
        check({v.name, "_busy_after"}, busy, 1'b0);
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            check($sformatf("%s_data%0d", v.name, i), got_d[i], exp_d[i]);
            check($sformatf("%s_last%0d", v.name, i), got_l[i], exp_l[i]);
        end
`ifdef WT_PACK_STALL_CNT_EN
        check({v.name, "_stall_cnt"}, stall_cnt, stall_seen);
`endif
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t;
        vecs[0] = '{17, 1, 1'b0, 0, 1'b0, 36, 1, "blk17"};
        vecs[1] = '{16, 2, 1'b0, 0, 1'b0, 66, 2, "blk16x2"};
        vecs[2] = '{17, 1, 1'b1, 0, 1'b0, 36, 1, "blk17_stall"};
        vecs[3] = '{5,  2, 1'b0, 3, 1'b0, 22, 2, "gap3"};
        vecs[4] = '{1,  1, 1'b0, 0, 1'b0, 3,  1, "blk1"};
        vecs[5] = '{33, 1, 1'b1, 2, 1'b0, 69, 1, "blk33_stall_gap"};
        vecs[6] = '{3,  1, 1'b0, 0, 1'b1, 7,  1, "busy_start"};

        bus.in_valid  = 1'b0;
        bus.in_wt     = '0;
        bus.in_scale  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_out_data", bus.out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            if (i == 0) begin
                // Partial-group job: beat 36 is the closing scale beat.
                if (got_d.size() >= 36) begin
                    check("blk17_last_pos", got_l[35], 1'b1);
                    check("blk17_scale_hi_zero", got_d[35][DW-1:SDW], '0);
                    check("blk17_scale_lo", got_d[35][SDW-1:0], mk_scale(16));
                    check("blk17_no_bubble", got_c[31] - got_c[0], 31);
                end else begin
                    check("blk17_beats_avail", got_d.size(), 36);
                end
                check("blk17_latency", got_c.size() > 0 ? got_c[0] - first_in_cyc : -1, 1);
                check("blk17_done_after_last", done_cyc - last_cyc, 1);
            end
        end

        // Reset in the middle of a job, then a fresh single-block job.
        clear_mon();
        ready_rand = 1'b0;
        mon_en = 1'b1;
        abort = 1'b0;
        pulse_start(17, 1);
        fork
            feed(17, 0);
            begin
                t = 0;
                while (got_d.size() < 10 && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                abort = 1'b1;
                rst_n = 1'b0;
            end
        join
        check("midrst_reached_beat10", got_d.size() >= 10, 1'b1);
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_out_last", bus.out_last, 1'b0);
        check("midrst_out_data", bus.out_data, '0);
`ifdef WT_PACK_STALL_CNT_EN
        check("midrst_stall_cnt", stall_cnt, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b0;

        // Offered data without a start must not be taken or produce beats.
        clear_mon();
        bus.in_wt    = mk_wt(99);
        bus.in_scale = mk_scale(99);
        bus.in_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("nostart_valid_seen", valid_seen, 0);
        check("nostart_accepted", accepted, 0);
        mon_en = 1'b0;

        run_vec(vecs[4]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hbm_wt_group_packer.md
HBM_WT_GROUP_PACKER -- requirements
Module: hbm_wt_group_packer

Interface
REQ-001 SHALL have parameter HBM_AXI_DATA_WIDTH, default 256: output beat width in bits.
REQ-002 SHALL have parameter T_QUANT_BLOCK, default 128: channels per quant block.
REQ-003 SHALL have parameter WT_DW, default 4: bits per INT4 weight.
REQ-004 SHALL have parameter SCALE_DW, default 16: bits per FP16 scale.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: one-cycle pulse that latches cfg and begins a job; ignored while busy.
REQ-008 SHALL have port cfg_blocks, input, 16 bits: quant blocks per row (CHin/T_QUANT_BLOCK), valid range 1..65535.
REQ-009 SHALL have port cfg_rows, input, 16 bits: rows per job (CHout), valid range 1..65535.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_wt (input, T_QUANT_BLOCK*WT_DW) and in_scale (input, SCALE_DW): one quantized block plus its scale.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, HBM_AXI_DATA_WIDTH) and out_last (output, 1, high on the final beat of each row).
REQ-012 SHALL have ports busy (output, 1) and done (output, 1, one-cycle pulse at job end).

Function
REQ-013 SHALL derive GROUP_BLOCKS = HBM_AXI_DATA_WIDTH/SCALE_DW (16) and BEATS_PER_BLOCK = T_QUANT_BLOCK*WT_DW/HBM_AXI_DATA_WIDTH (2).
REQ-014 SHALL emit each row as groups; a group is up to GROUP_BLOCKS blocks of weight beats followed by exactly one scale beat.
REQ-015 SHALL use FSM states IDLE, WT, SCALE and DONE.
REQ-016 SHALL make these transitions: IDLE->WT on start; WT->SCALE after the last weight beat of a group is handshaked; SCALE->WT after the scale beat when row blocks remain; SCALE->WT (next row) otherwise; SCALE->DONE after the last row; DONE->IDLE after one cycle with done=1.
REQ-017 SHALL split each block across beats with beat0 = in_wt[255:0] (lower channels) first and beat1 = in_wt[511:256] second.
REQ-018 SHALL place the scale of group block k at scale-beat bits [16k+15:16k]; in a partial last group, bits of unused slots SHALL be 0.
REQ-019 SHALL accept an input block only on in_valid && in_ready.
REQ-020 SHALL drive in_ready = (state==WT) && the group is not yet full && (holding register empty, or the final beat of the held block is handshaked in the same cycle).
REQ-021 SHALL present the first beat of an accepted block on out_data in the next cycle (1-cycle latency) and sustain one beat per cycle with no bubbles under continuous valid/ready.
REQ-022 SHALL hold out_data, out_valid and out_last stable while out_valid && !out_ready.
REQ-023 SHALL assert out_last only on the scale beat of the final group of each row.
REQ-024 SHALL clear the scale buffer after each scale beat.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-job: go to IDLE; drive out_valid, in_ready, busy, done and out_last to 0; clear out_data, the scale buffer and all counters to 0; discard any partial job.
REQ-026 SHALL require a new start pulse after reset release before any output is produced.

Configuration
REQ-027 SHALL compile in, when WT_PACK_STALL_CNT_EN is defined, an output port stall_cnt (32 bits) counting cycles with out_valid && !out_ready; the count clears on start, saturates at 0xFFFFFFFF and resets to 0.
REQ-028 SHALL have neither the stall_cnt port nor its logic when WT_PACK_STALL_CNT_EN is undefined.

Structure
REQ-029 SHALL define the FSM state enum and the GROUP_BLOCKS/BEATS_PER_BLOCK constant functions in the shared package hbm_wt_pkg.
REQ-030 SHALL implement the scale accumulation register in one sub-module, hbm_scale_collector (write with slot index, clear, read full beat).

Verification
REQ-031 SHALL cover: cfg_blocks=17, cfg_rows=1, out_ready=1 -> 32 weight beats, scale beat, 2 weight beats, scale beat with only bits[15:0] nonzero; 36 beats total; out_last on beat 36; done one cycle later.
REQ-032 SHALL cover: cfg_blocks=16, cfg_rows=2 -> 33 beats per row, out_last on beats 33 and 66, no partial group.
REQ-033 SHALL cover: out_ready toggling with 50% random stalls -> beat sequence identical to the stall-free run; data stable during stalls; stall_cnt equals the stalled cycles when WT_PACK_STALL_CNT_EN is defined.
REQ-034 SHALL cover: in_valid gaps of 3 cycles between blocks -> no spurious out_valid and correct order.
REQ-035 SHALL cover: rst_n asserted after beat 10 of a job, then restart with cfg_blocks=1, cfg_rows=1 -> 3 beats (2 weight, 1 scale) with no residue from the aborted job.
REQ-036 SHALL cover: start pulsed while busy -> ignored; cfg unchanged.
